// File: rtl/elev_scan_ctrl.sv
// N-floor SCAN elevator controller: per-floor hall-up/hall-down/car pending bits, travel and door timers.
// Optional macro DOOR_REOPEN_EN: same-floor car or sweep-direction hall requests during DOOR extend the open door.
module elev_scan_ctrl #(
   parameter int unsigned N_FLOORS      = 4,
   parameter int unsigned FLOOR_W       = 2,
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] hall_up_req,
   input  logic [N_FLOORS-1:0] hall_dn_req,
   input  logic [N_FLOORS-1:0] car_req,
   output logic [1:0]          dout,
   output logic [FLOOR_W-1:0]  cur_floor,
   output logic                door_open,
   output logic [N_FLOORS-1:0] pend_up,
   output logic [N_FLOORS-1:0] pend_dn,
   output logic [N_FLOORS-1:0] pend_car,
   output logic                busy
);

   localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
   localparam logic [TW-1:0] TRAV_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
   localparam logic [1:0] CMD_UP   = 2'b00;
   localparam logic [1:0] CMD_DN   = 2'b01;
   localparam logic [1:0] CMD_STAY = 2'b10;
   // Top floor has no hall-up button, floor 0 has no hall-down button.
   localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MOVE_UP = 2'd1,
      S_MOVE_DN = 2'd2,
      S_DOOR    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
   logic [N_FLOORS-1:0]  pend_up_q, pend_up_d, pend_dn_q, pend_dn_d, pend_car_q, pend_car_d;
   logic [TW-1:0]        trav_q, trav_d;
   logic [DW-1:0]        door_q, door_d;
   logic                 dir_up_q, dir_up_d;
   logic [1:0]           dout_q, dout_d;
   logic                 door_open_q, door_open_d;
   logic                 busy_q, busy_d;

   logic [N_FLOORS-1:0]  pend_all, clr_up, clr_dn, clr_car;
   logic [FLOOR_W-1:0]   near_up, near_dn, nxt_floor;
   logic                 above, below, go_up;
   logic                 mv_up, arr_ahead, same_h, opp_h, reopen;

   function automatic logic any_gt(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < N_FLOORS; i++)
         if (FLOOR_W'(i) > f) r = r | v[i];
      return r;
   endfunction

   function automatic logic any_lt(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < N_FLOORS; i++)
         if (FLOOR_W'(i) < f) r = r | v[i];
      return r;
   endfunction

   assign pend_all = pend_up_q | pend_dn_q | pend_car_q;
   assign above    = any_gt(pend_all, cur_floor_q);
   assign below    = any_lt(pend_all, cur_floor_q);

   // Closest pending floor on each side of the car.
   always_comb begin : nearest
      near_up = '0;
      near_dn = '0;
      for (int unsigned i = 0; i < N_FLOORS; i++) begin
         if (pend_all[N_FLOORS-1-i] && FLOOR_W'(N_FLOORS-1-i) > cur_floor_q)
            near_up = FLOOR_W'(N_FLOORS-1-i);
         if (pend_all[i] && FLOOR_W'(i) < cur_floor_q)
            near_dn = FLOOR_W'(i);
      end
   end

   assign go_up = above && (!below || ((near_up - cur_floor_q) <= (cur_floor_q - near_dn)));

   always_comb begin : next_state
      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      trav_d      = trav_q;
      door_d      = door_q;
      dir_up_d    = dir_up_q;
      clr_up      = '0;
      clr_dn      = '0;
      clr_car     = '0;
      nxt_floor   = cur_floor_q;
      mv_up       = 1'b0;
      arr_ahead   = 1'b0;
      same_h      = 1'b0;
      opp_h       = 1'b0;
      reopen      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pend_all[cur_floor_q]) begin
               state_d  = S_DOOR;
               door_d   = DOOR_LOAD;
               dir_up_d = !(pend_dn_q[cur_floor_q] && !pend_up_q[cur_floor_q] && !pend_car_q[cur_floor_q]);
               clr_up[cur_floor_q]  = 1'b1;
               clr_dn[cur_floor_q]  = 1'b1;
               clr_car[cur_floor_q] = 1'b1;
            end else if (above || below) begin
               state_d  = go_up ? S_MOVE_UP : S_MOVE_DN;
               trav_d   = TRAV_LOAD;
               dir_up_d = go_up;
            end
         end

         S_MOVE_UP, S_MOVE_DN: begin
            if (trav_q != '0) begin
               trav_d = trav_q - TW'(1);
            end else begin
               // Arrival: decide on the floor just reached.
               mv_up       = (state_q == S_MOVE_UP);
               nxt_floor   = mv_up ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);
               cur_floor_d = nxt_floor;
               arr_ahead   = mv_up ? any_gt(pend_all, nxt_floor) : any_lt(pend_all, nxt_floor);
               same_h      = mv_up ? pend_up_q[nxt_floor] : pend_dn_q[nxt_floor];
               opp_h       = mv_up ? pend_dn_q[nxt_floor] : pend_up_q[nxt_floor];
               if (pend_car_q[nxt_floor] || same_h || (opp_h && !arr_ahead)) begin
                  state_d = S_DOOR;
                  door_d  = DOOR_LOAD;
                  clr_car[nxt_floor] = 1'b1;
                  clr_up[nxt_floor]  = mv_up ? 1'b1 : !arr_ahead;
                  clr_dn[nxt_floor]  = mv_up ? !arr_ahead : 1'b1;
               end else if (arr_ahead) begin
                  trav_d = TRAV_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_DOOR: begin
`ifdef DOOR_REOPEN_EN
            reopen = pend_car_q[cur_floor_q] ||
                     (dir_up_q ? pend_up_q[cur_floor_q] : pend_dn_q[cur_floor_q]);
`endif
            if (reopen) begin
               door_d = DOOR_LOAD;
               clr_car[cur_floor_q] = 1'b1;
               clr_up[cur_floor_q]  = dir_up_q;
               clr_dn[cur_floor_q]  = !dir_up_q;
            end else if (door_q != '0) begin
               door_d = door_q - DW'(1);
            end else if (dir_up_q ? above : below) begin
               state_d = dir_up_q ? S_MOVE_UP : S_MOVE_DN;
               trav_d  = TRAV_LOAD;
            end else if (dir_up_q ? below : above) begin
               state_d  = dir_up_q ? S_MOVE_DN : S_MOVE_UP;
               trav_d   = TRAV_LOAD;
               dir_up_d = !dir_up_q;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // New pulses win over a same-cycle clear.
      pend_up_d  = (pend_up_q  & ~clr_up)  | (hall_up_req & UP_MASK);
      pend_dn_d  = (pend_dn_q  & ~clr_dn)  | (hall_dn_req & DN_MASK);
      pend_car_d = (pend_car_q & ~clr_car) | car_req;

      dout_d      = (state_d == S_MOVE_UP) ? CMD_UP : ((state_d == S_MOVE_DN) ? CMD_DN : CMD_STAY);
      door_open_d = (state_d == S_DOOR);
      busy_d      = (state_d != S_IDLE) || (|(pend_up_d | pend_dn_d | pend_car_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_floor_q <= '0;
         pend_up_q   <= '0;
         pend_dn_q   <= '0;
         pend_car_q  <= '0;
         trav_q      <= '0;
         door_q      <= '0;
         dir_up_q    <= 1'b1;
         dout_q      <= CMD_STAY;
         door_open_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         pend_up_q   <= pend_up_d;
         pend_dn_q   <= pend_dn_d;
         pend_car_q  <= pend_car_d;
         trav_q      <= trav_d;
         door_q      <= door_d;
         dir_up_q    <= dir_up_d;
         dout_q      <= dout_d;
         door_open_q <= door_open_d;
         busy_q      <= busy_d;
      end
   end

   assign dout      = dout_q;
   assign cur_floor = cur_floor_q;
   assign door_open = door_open_q;
   assign pend_up   = pend_up_q;
   assign pend_dn   = pend_dn_q;
   assign pend_car  = pend_car_q;
   assign busy      = busy_q;

endmodule
